// File: rtl/mem_string_reader.sv
// Streams length bytes (ReadData[7:0]) from a word memory starting at base_addr; 2 cycles/char, HOLD stalls on out_ready.
// Optional MEM_READER_NULL_TERM_EN: a zero word read ends the transfer early without emitting a character.
module mem_string_reader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] length,
    output logic [31:0]      Address,
    output logic             MemRead,
    output logic             MemWrite,
    input  logic [31:0]      ReadData,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    state_t           state;
    logic [AW-1:0]    addr;
    logic [CNT_W-1:0] len_q;
    logic [31:0]      base_mod;
    logic [AW-1:0]    addr_nxt;
    logic [CNT_W-1:0] count_inc;
    logic             null_word;
    logic             unused_bits;

    assign base_mod  = base_addr % 32'(DEPTH);
    assign addr_nxt  = (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
    assign count_inc = count + CNT_W'(1);

`ifdef MEM_READER_NULL_TERM_EN
    assign null_word = (ReadData == 32'd0);
`else
    assign null_word = 1'b0;
`endif

    assign unused_bits = ^{ReadData[31:8], base_mod[31:AW]};

    // Control outputs decode directly from the state register.
    assign Address  = {{(32 - AW){1'b0}}, addr};
    assign MemRead  = (state == READ);
    assign MemWrite = 1'b0;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            len_q     <= '0;
            count     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr  <= base_mod[AW-1:0];
                        len_q <= length;
                        count <= '0;
                        state <= (length != '0) ? READ : DONE;
                    end
                end
                READ: begin
                    if (null_word) begin
                        state <= DONE;
                    end else begin
                        out_data  <= ReadData[7:0];
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        count     <= count_inc;
                        addr      <= addr_nxt;
                        state     <= (count_inc == len_q) ? DONE : READ;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_string_reader.sv
// Randomized bench for mem_string_reader: expected chars/addresses come from a queue model of the memory walk.
module tb_mem_string_reader;
    localparam int DEPTH = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      base_addr;
    logic [CNT_W-1:0] length;
    logic [31:0]      Address;
    logic             MemRead;
    logic             MemWrite;
    logic [31:0]      ReadData;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;

    logic [31:0] mem [DEPTH];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign ReadData = mem[Address % DEPTH];

    mem_string_reader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_text();
        int txt [13] = '{65, 110, 103, 101, 108, 32, 77, 101, 114, 99, 97, 100, 111};
        for (int i = 0; i < DEPTH; i++) mem[i] = (i < 13) ? 32'(txt[i]) : 32'd0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_addr"}, Address, 0);
        chk({tag, "_memread"}, 32'(MemRead), 0);
        chk({tag, "_memwrite"}, 32'(MemWrite), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_count"}, 32'(count), 0);
    endtask

    // mode 0: always ready, 1: random ready, 2: stall 3 cycles on the 2nd character
    task automatic run_xfer(input logic [31:0] b, input int len, input int mode);
        logic [7:0] exp_c [$];
        int         exp_a [$];
        int         nacc, nrd, first_v, done_cyc, stall_left, a;
        logic       stalled, rdy, got_done;
        logic [31:0] st_d, st_a;

        for (int i = 0; i < len; i++) begin
            a = int'(((b % 32'(DEPTH)) + 32'(i)) % 32'(DEPTH));
            exp_a.push_back(a);
`ifdef MEM_READER_NULL_TERM_EN
            if (mem[a] == 32'd0) break;
`endif
            exp_c.push_back(mem[a][7:0]);
        end

        @(negedge clk);
        base_addr = b; length = CNT_W'(len); start = 1'b1; out_ready = 1'b0;
        nacc = 0; nrd = 0; first_v = -1; done_cyc = -1; stall_left = 3;
        stalled = 1'b0; got_done = 1'b0; st_d = 0; st_a = 0;

        for (int cyc = 1; cyc <= 400 && !got_done; cyc++) begin
            @(negedge clk);
            chk("memwrite", 32'(MemWrite), 0);
            if (stalled) begin
                chk("stall_valid", 32'(out_valid), 1);
                chk("stall_data", 32'(out_data), st_d);
                chk("stall_memread", 32'(MemRead), 0);
                chk("stall_addr", Address, st_a);
            end
            if (MemRead) begin
                if (nrd < exp_a.size()) chk("address", Address, 32'(exp_a[nrd]));
                else chk("extra_read", 32'(nrd + 1), 32'(exp_a.size()));
                nrd++;
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (done) begin
                got_done = 1'b1; done_cyc = cyc;
                chk("busy_at_done", 32'(busy), 1);
                chk("valid_at_done", 32'(out_valid), 0);
                start = 1'b0; out_ready = 1'b0; stalled = 1'b0;
            end else begin
                chk("busy", 32'(busy), 1);
                case (mode)
                    1: rdy = ($urandom % 3) != 0;
                    2: rdy = !(out_valid && nacc == 1 && stall_left > 0);
                    default: rdy = 1'b1;
                endcase
                if (mode == 2 && !rdy) stall_left--;
                out_ready = rdy;
                stalled = out_valid && !rdy;
                if (stalled && nacc < exp_c.size()) begin
                    st_d = 32'(exp_c[nacc]);
                    st_a = 32'(exp_a[nacc]);
                end
                if (out_valid && rdy) begin
                    if (nacc < exp_c.size()) chk("char", 32'(out_data), 32'(exp_c[nacc]));
                    else chk("extra_char", 32'(nacc + 1), 32'(exp_c.size()));
                    nacc++;
                end
                // Inputs after the latch edge must be ignored
                start = 1'($urandom % 2);
                base_addr = $urandom;
                length = CNT_W'($urandom);
            end
        end

        if (!got_done) chk("done_timeout", 0, 1);
        chk("chars", 32'(nacc), 32'(exp_c.size()));
        chk("reads", 32'(nrd), 32'(exp_a.size()));
        chk("count", 32'(count), 32'(exp_c.size()));
        if (exp_c.size() > 0) chk("first_valid_cyc", 32'(first_v), 2);
        if (len == 0) chk("len0_done_cyc", 32'(done_cyc), 1);
        if (mode == 2 && len >= 3) chk("stall_cycles_used", 32'(stall_left), 0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("count_hold", 32'(count), 32'(exp_c.size()));
    endtask

    initial begin
        int nv;
        reset = 1'b1; start = 1'b0; base_addr = 0; length = 0; out_ready = 1'b0;
        load_text();
        #3;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        run_xfer(32'd0, 5, 0);
        run_xfer(32'd0, 0, 0);
        run_xfer(32'd30, 4, 0);
        run_xfer(32'd0, 3, 2);
        run_xfer(32'd6, 20, 0);
        run_xfer(32'd70, 40, 1);

        // Abort in HOLD of the 3rd character
        @(negedge clk);
        base_addr = 0; length = 5; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nv = 0;
        for (int c = 0; c < 40 && nv < 3; c++) begin
            @(negedge clk);
            if (out_valid) begin
                nv++;
                if (nv == 3) out_ready = 1'b0;
            end
        end
        chk("abort_reached_third", 32'(nv), 3);
        chk("abort_third_data", 32'(out_data), mem[2] & 32'hff);
        #1 reset = 1'b1;
        #1 check_all_zero("abort");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        nv = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || busy) nv++;
        end
        chk("abort_no_done", 32'(nv), 0);
        run_xfer(32'd2, 2, 0);

        for (int i = 0; i < DEPTH; i++) mem[i] = ($urandom % 6 == 0) ? 32'd0 : $urandom;
        for (int t = 0; t < 25; t++) begin
            run_xfer(($urandom % 2) ? $urandom : 32'($urandom_range(0, DEPTH - 1)),
                     $urandom_range(0, 45), int'($urandom % 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
